apb_ram_slave: RTL and testbench
================================

# apb_ram_slave

Parametrised APB4 memory-mapped slave: a DEPTH×DATA_WIDTH register array with byte strobes, programmable wait states and, optionally, error signalling. Sits behind the APB bridge as the generic scratch/configuration store for the SDRAM/AXI subsystem, replacing the fixed 16×32, no-wait-state slave. All logic runs on the rising PCLK edge.

## Interface
- DATA_WIDTH, 32: data bus width; multiple of 8, at least 8.
- ADDR_WIDTH, 8: PADDR width (byte address).
- DEPTH, 16: number of words; must satisfy DEPTH·DATA_WIDTH/8 ≤ 2^ADDR_WIDTH.
- WAIT_STATES, 0: access-phase cycles with PREADY low before PREADY rises; 0..15.
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  reset PRESETn, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write enables; ignored on reads.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  transfer error, valid only while PREADY = 1.

## Operation
- OFFS = log2(DATA_WIDTH/8); word index = PADDR[ADDR_WIDTH-1:OFFS]; misaligned = PADDR[OFFS-1:0] ≠ 0 (never for DATA_WIDTH = 8).
- err = (index ≥ DEPTH) or misaligned; computed at the setup edge, registered.
- FSM states IDLE, WAIT, READY; cnt width log2(WAIT_STATES+1), minimum 1.
- IDLE: on edge with PSEL & !PENABLE → if WAIT_STATES = 0 go READY (load outputs, below), else WAIT with cnt = WAIT_STATES−1. Otherwise stay.
- WAIT: if !PSEL → IDLE (aborted, no write). Else if cnt = 0 → READY and load outputs; else cnt−1.
- Load outputs: PREADY←1; PSLVERR←err; read: PRDATA←err ? 0 : mem[index].
- READY: edge completes the transfer; write with !err commits lanes where PSTRB[i] = 1, other lanes unchanged; PREADY←0, PSLVERR←0; → IDLE. Errored writes leave memory untouched.
- PRDATA holds its last value across writes and idle cycles.
- Memory contents are not reset; unwritten words read undefined.

## Timing
- Reset values: PREADY 0, PSLVERR 0, PRDATA 0, state IDLE, cnt 0; memory unchanged.
- Read/write latency: setup cycle + (WAIT_STATES+1) access cycles; PREADY high exactly one cycle per transfer.
- Back-to-back: next setup cycle may directly follow the PREADY cycle; no idle gap required.
- PSEL dropped mid-access: return to IDLE, PREADY stays 0, no write, PRDATA unchanged.
- Reset asserted mid-transfer: outputs to reset values immediately; pending write lost.
- Read after write to the same word: new data returned, no hazard.

## Configuration
- APB_RAM_PSLVERR_EN defined: error detection as above.
- Undefined: PSLVERR tied 0; out-of-range/misaligned writes silently dropped, reads return 0, identical timing.

## Structure
- Shared package apb_pkg: FSM state enum (IDLE/WAIT/READY), APB response constants (OKAY/ERR), helper for strobe width.
- One sub-module apb_ram_array: DEPTH×DATA_WIDTH storage, byte-enable synchronous write port, synchronous read port; FSM and decode stay in the top.

## Test plan
- Reset: PRESETn low mid-transfer → PREADY 0, PSLVERR 0, PRDATA 0 within same cycle.
- WAIT_STATES = 0: write 0xDEADBEEF to 0x08, read 0x08 → PREADY in first access cycle, PRDATA 0xDEADBEEF, PSLVERR 0.
- PSTRB = 4'b0101 write 0x11223344 over 0xAABBCCDD at 0x04 → read returns 0xAA22CC44.
- WAIT_STATES = 3: read → PREADY low for 3 access cycles, high on the 4th; back-to-back write then read with no idle cycle both complete.
- APB_RAM_PSLVERR_EN: write to 0x40 (index 16) and to 0x02 → PSLVERR 1 with PREADY; subsequent reads of 0x00 unchanged; errored read PRDATA 0.
- Abort: drop PSEL during WAIT of a write to 0x0C → no PREADY, word 0x0C unchanged.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB RAM slave: FSM state encoding, APB
// response codes and width helpers used by the top and the storage array.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // Byte-lane count for a data bus width.
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  // Wait-state counter width; at least one bit even with no wait states.
  function automatic int cnt_w(input int ws);
    return (ws > 0) ? $clog2(ws + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_ram_slave_if.sv
// APB4 bus bundle between bridge (master) and the RAM slave.
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB (master -> slave),
//          PRDATA, PREADY, PSLVERR (slave -> master).
interface apb_ram_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_ram_array.sv
// DEPTH x DATA_WIDTH storage with a byte-enable synchronous write port and a
// synchronous read port. The read register doubles as the bus PRDATA register:
// it resets to 0, loads only on re, and loads 0 when rclr flags a bad access.
// Ports: clk, rst_n (async low, read register only), we/waddr/wdata/wstrb,
//        re/rclr/raddr, rdata.
module apb_ram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic                    rclr,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rclr ? '0 : mem[raddr];
  end
endmodule

// File: rtl/apb_ram_slave.sv
// APB4 RAM slave: DEPTH x DATA_WIDTH word store with byte strobes and
// WAIT_STATES access-phase wait cycles. Decode and the IDLE/WAIT/READY FSM
// live here; storage is in apb_ram_array.
// Ports: PCLK, PRESETn (async low), bus (apb_ram_slave_if.slave).
// Build option: APB_RAM_PSLVERR_EN enables PSLVERR on out-of-range or
// misaligned accesses; without it PSLVERR stays 0 and such accesses are
// still dropped (writes) or return 0 (reads) with identical timing.
module apb_ram_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input logic           PCLK,
  input logic           PRESETn,
  apb_ram_slave_if.slave bus
);
  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = cnt_w(WAIT_STATES);
`ifdef APB_RAM_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  apb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             pready, pslverr;
  logic [IDX_W-1:0] idx, idx_q;
  logic             mis, err, err_q, wr_q;

  // Address decode is combinational; err/index are captured at the setup edge.
  assign idx = bus.PADDR[ADDR_WIDTH-1:OFFS];
  generate
    if (OFFS > 0) begin : g_mis
      assign mis = |bus.PADDR[OFFS-1:0];
    end else begin : g_nomis
      assign mis = 1'b0;
    end
  endgenerate
  assign err = mis || (32'(idx) >= 32'(DEPTH));

  wire setup    = bus.PSEL && !bus.PENABLE;
  wire ld_idle  = (state == IDLE) && setup && (WAIT_STATES == 0);
  wire ld_wait  = (state == WAIT) && bus.PSEL && (cnt == '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= RESP_OKAY;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (setup) begin
          idx_q <= idx;
          err_q <= err;
          wr_q  <= bus.PWRITE;
          if (WAIT_STATES == 0) begin
            state   <= READY;
            pready  <= 1'b1;
            pslverr <= (ERR_EN && err) ? RESP_ERR : RESP_OKAY;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(WAIT_STATES - 1);
          end
        end
        WAIT: begin
          if (!bus.PSEL) begin
            state <= IDLE;               // aborted: nothing committed
          end else if (cnt == '0) begin
            state   <= READY;
            pready  <= 1'b1;
            pslverr <= (ERR_EN && err_q) ? RESP_ERR : RESP_OKAY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READY: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= RESP_OKAY;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads load PRDATA on the same edge PREADY rises; writes commit on the
  // edge that ends the PREADY cycle, so a following read sees the new data.
  logic [DATA_WIDTH-1:0] rdata;

  apb_ram_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    ((state == READY) && wr_q && !err_q),
    .waddr (idx_q[AW-1:0]),
    .wdata (bus.PWDATA),
    .wstrb (bus.PSTRB),
    .re    ((ld_idle && !bus.PWRITE) || (ld_wait && !wr_q)),
    .rclr  (ld_idle ? err : err_q),
    .raddr (ld_idle ? idx[AW-1:0] : idx_q[AW-1:0]),
    .rdata (rdata)
  );

  assign bus.PRDATA  = rdata;
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pslverr;
endmodule

// File: tb/tb_apb_ram_slave.sv
// Bench for apb_ram_slave: two instances (WAIT_STATES 0 and 3) share one
// APB driver, PSEL is steered to the target. Expected data comes from a
// word-array model of the memory updated by byte-lane arithmetic.
module tb_apb_ram_slave;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  int          tgt = 0;

  apb_ram_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if0 ();
  apb_ram_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if1 ();

  assign if0.PSEL = psel && (tgt == 0);
  assign if1.PSEL = psel && (tgt == 1);
  assign if0.PENABLE = penable;  assign if1.PENABLE = penable;
  assign if0.PWRITE  = pwrite;   assign if1.PWRITE  = pwrite;
  assign if0.PADDR   = paddr;    assign if1.PADDR   = paddr;
  assign if0.PWDATA  = pwdata;   assign if1.PWDATA  = pwdata;
  assign if0.PSTRB   = pstrb;    assign if1.PSTRB   = pstrb;

  apb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(if0.slave));
  apb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(3)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(if1.slave));

  wire        rdy   = (tgt == 0) ? if0.PREADY  : if1.PREADY;
  wire        err_o = (tgt == 0) ? if0.PSLVERR : if1.PSLVERR;
  wire [31:0] rdat  = (tgt == 0) ? if0.PRDATA  : if1.PRDATA;

`ifdef APB_RAM_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_chk = 0, n_fail = 0;
  logic [31:0] mm [2][16];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // One complete transfer starting #1 after an edge; returns #1 after the
  // edge that ends the PREADY cycle with PSEL low, so an immediate next call
  // is a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd);
    int n;
    bit e;
    e = (a[7:2] >= 6'd16) || (a[1:0] != 2'b00);
    tgt = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = a; pwdata = wd; pstrb = st;
    @(posedge PCLK); #1;
    penable = 1'b1;
    n = 0;
    while (!rdy && n < 40) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(ws(d)));
    chk("pslverr", 32'(err_o), 32'(ERR_EN && e));
    if (!wr) begin
      chk("prdata", rdat, e ? 32'h0 : mm[d][a[5:2]]);
      last_rd[d] = e ? 32'h0 : mm[d][a[5:2]];
    end else begin
      chk("prdata_hold", rdat, last_rd[d]);
      if (!e)
        for (int b = 0; b < 4; b++)
          if (st[b]) mm[d][a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
    end
    rd = rdat;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    chk("pready_pulse", 32'(rdy), 32'h0);
  endtask

  task automatic idle_cycle();
    @(posedge PCLK); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  a;
    last_rd[0] = '0; last_rd[1] = '0;

    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready0", 32'(if0.PREADY), 32'h0);
    chk("rst_pslverr0", 32'(if0.PSLVERR), 32'h0);
    chk("rst_prdata0", if0.PRDATA, 32'h0);
    chk("rst_pready1", 32'(if1.PREADY), 32'h0);
    chk("rst_prdata1", if1.PRDATA, 32'h0);
    PRESETn = 1'b1;
    idle_cycle();

    // Fill both memories so every later read has a known expectation
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        xfer(d, 1'b1, 8'(i * 4), $urandom, 4'hF, rd);

    // Zero-wait write/read
    xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, rd);
    xfer(0, 1'b0, 8'h08, '0, 4'h0, rd);
    chk("rw_0x08", rd, 32'hDEADBEEF);

    // Byte-strobe merge
    xfer(0, 1'b1, 8'h04, 32'hAABBCCDD, 4'hF, rd);
    xfer(0, 1'b1, 8'h04, 32'h11223344, 4'b0101, rd);
    xfer(0, 1'b0, 8'h04, '0, 4'h0, rd);
    chk("strb_merge", rd, 32'hAA22CC44);

    // Three wait states, back-to-back write then read
    xfer(1, 1'b0, 8'h14, '0, 4'h0, rd);
    xfer(1, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, rd);
    xfer(1, 1'b0, 8'h10, '0, 4'h0, rd);
    chk("ws3_b2b", rd, 32'hCAFEF00D);

    // Out-of-range and misaligned accesses
    xfer(0, 1'b0, 8'h00, '0, 4'h0, rd);
    xfer(0, 1'b1, 8'h40, 32'h55555555, 4'hF, rd);
    xfer(0, 1'b1, 8'h02, 32'h66666666, 4'hF, rd);
    xfer(0, 1'b0, 8'h00, '0, 4'h0, rd);
    xfer(0, 1'b0, 8'h41, '0, 4'h0, rd);
    xfer(1, 1'b0, 8'h80, '0, 4'h0, rd);

    // Abort a wait-state write to 0x0C by dropping PSEL
    tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h0C; pwdata = ~mm[1][3]; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_pready", 32'(rdy), 32'h0);
      idle_cycle();
    end
    chk("abort_prdata", rdat, last_rd[1]);
    xfer(1, 1'b0, 8'h0C, '0, 4'h0, rd);

    // Reset during the PREADY cycle of a write: outputs clear at once,
    // write is lost
    xfer(0, 1'b0, 8'h08, '0, 4'h0, rd);
    tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h08; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    chk("rst_mid_ready", 32'(rdy), 32'h1);
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_pready", 32'(if0.PREADY), 32'h0);
    chk("rst_mid_pslverr", 32'(if0.PSLVERR), 32'h0);
    chk("rst_mid_prdata", if0.PRDATA, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    idle_cycle();
    xfer(0, 1'b0, 8'h08, '0, 4'h0, rd);
    chk("rst_write_lost", rd, 32'hDEADBEEF);

    // Randomized traffic
    for (int k = 0; k < 160; k++) begin
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 15) * 4);
      else                           a = 8'($urandom);
      xfer(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom,
           4'($urandom), rd);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
